prbs_rx_checker: RTL and testbench
==================================

// Module: prbs_rx_checker
// PURPOSE
//  Self-synchronous parallel PRBS checker for the TX loopback/deserialised return path.
//  - Consumes W-bit words from the deserialiser: the same serial stream the 16:4 / 4:1 mux chain emits.
//  - Locks to the PRBS stream and counts bit errors and checked bits for BER measurement.
//  - Debug/bring-up block; sits downstream of the TX serialiser and output buffer.
// PARAMETERS
//  W            16      word width; bits checked per valid word
//  N_PRBS       7       PRBS order; history register length
//  EQN          7'h60   tap mask; EQN[j]=1 -> tap at delay j+1 (default x^7+x^6+1)
//  LOCK_WORDS   8       consecutive error-free words needed to declare lock
//  UNLOCK_WORDS 4       consecutive errored words needed to drop lock
//  CNT_W        32      width of err_cnt and bit_cnt
// PORTS
//  clk        in   1      checker clock (one word per cycle max)
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      enable; 0 forces IDLE
//  din_valid  in   1      din carries a valid word this cycle
//  din        in   W      received word; din[W-1] is earliest serial bit, din[0] latest
//  clr_cnt    in   1      synchronous clear of err_cnt/bit_cnt
//  locked     out  1      checker in LOCKED state
//  err_word   out  1      1-cycle pulse: last valid word had >=1 bit error
//  err_cnt    out  CNT_W  saturating bit-error count (LOCKED only)
//  bit_cnt    out  CNT_W  saturating checked-bit count (LOCKED only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE.
//    - locked=0, err_word=0, err_cnt=0, bit_cnt=0.
//    - History=0, clean/bad run counters=0.
//  - Serial order within word: s[0]=din[W-1] ... s[W-1]=din[0]; s[-1]=hist[0] (newest), s[-N_PRBS]=hist[N_PRBS-1].
//  - Expected bit: e[k] = XOR over j with EQN[j]=1 of s[k-j-1]. Expectations use received bits, not regenerated ones.
//  - Error bits: err[k] = s[k] ^ e[k]. nerr = popcount(err), 0..W. All combinational on din + hist.
//  - On every valid word in SEARCH/LOCKED, hist <= last N_PRBS bits of s. Hist holds when din_valid=0 or in IDLE.
//  - Latency: word sampled at edge T. At edge T+1 these update together:
//    - err_word, err_cnt, bit_cnt;
//    - run counters and state.
//    - When din_valid=0, err_word=0 next cycle and everything else holds.
//  - FSM:
//    - IDLE: en=1 -> SEARCH. Run counters cleared.
//    - SEARCH:
//      - Valid word with nerr=0 increments clean_run. Any error clears it to 0.
//      - clean_run reaching LOCK_WORDS -> LOCKED; locked=1 on that same edge.
//    - LOCKED:
//      - Valid word with nerr>0 increments bad_run; nerr=0 clears it.
//      - bad_run reaching UNLOCK_WORDS -> SEARCH, clean_run=0.
//    - en=0 in any state -> IDLE next edge, locked=0. Counters hold their values.
//  - Counting occurs only for valid words while in LOCKED, including the word that causes unlock.
//    - err_cnt += nerr; bit_cnt += W.
//    - Each saturates at 2^CNT_W-1 and never wraps.
//  - clr_cnt=1 sets err_cnt=bit_cnt=0 at the next edge. Clear wins over a same-cycle increment; that word is not counted.
//  - err_word is reported in every state except IDLE.
//  - Async reset mid-word: all outputs return to reset values immediately; no partial update.
// TESTING
//  1. Clean PRBS7 stream, W=16, din_valid=1 -> locked=1 after 8 clean words (+1 priming word if hist stale).
//     After 100 locked words: err_cnt=0, bit_cnt=1600.
//  2. Locked, flip one bit of a word -> err_cnt +3 (error at k, k+6, k+7).
//     err_word pulses on 1 or 2 words; locked stays 1.
//  3. Locked, feed 4 all-random errored words -> locked=0 after 4th word; err_cnt grows by the summed nerr of those 4.
//  4. din_valid toggled 1/0 with clean data -> lock counts only valid words; hist and counters hold on gaps.
//  5. CNT_W=8, errors injected past 255 -> err_cnt holds 255.
//     clr_cnt asserted together with an errored word -> err_cnt=0 next cycle.
//  6. rst_n low mid-stream (asynchronous to clk) -> outputs 0 immediately.
//     After release with en=1: relock in LOCK_WORDS(+1) words.
//     en=0 mid-stream -> IDLE, counters retained.

Source files
------------

// File: rtl/prbs_rx_checker.sv
// ---------------------------------------------------------------------------
// prbs_rx_checker
//
// Self-synchronous parallel PRBS checker for the deserialised TX loopback
// path. Each received bit is predicted from earlier *received* bits through
// the tap mask EQN, so the checker needs no seed and no generator of its own.
// Once enough consecutive error-free words have been seen, the checker
// declares lock. While locked it accumulates bit-error and checked-bit counts
// for BER measurement.
//
// Ports
//   clk        checker clock, at most one word per cycle
//   rst_n      asynchronous active-low reset
//   en         enable; low forces the IDLE state
//   din_valid  din carries a valid word this cycle
//   din[W]     received word, din[W-1] is the earliest serial bit
//   clr_cnt    synchronous clear of err_cnt / bit_cnt
//   locked     high while in the LOCKED state
//   err_word   one-cycle pulse: last valid word had at least one bit error
//   err_cnt    saturating bit-error count, accumulated only while locked
//   bit_cnt    saturating checked-bit count, accumulated only while locked
// ---------------------------------------------------------------------------
module prbs_rx_checker #(
  parameter int unsigned          W            = 16,
  parameter int unsigned          N_PRBS       = 7,
  parameter logic [N_PRBS-1:0]    EQN          = 7'h60,
  parameter int unsigned          LOCK_WORDS   = 8,
  parameter int unsigned          UNLOCK_WORDS = 4,
  parameter int unsigned          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din_valid,
  input  logic [W-1:0]     din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_word,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned EXT_W   = N_PRBS + W;
  localparam int unsigned NERR_W  = $clog2(W + 1);
  localparam int unsigned CLEAN_W = $clog2(LOCK_WORDS + 1);
  localparam int unsigned BAD_W   = $clog2(UNLOCK_WORDS + 1);

  localparam logic [CLEAN_W-1:0] LOCK_LAST   = CLEAN_W'(LOCK_WORDS - 1);
  localparam logic [BAD_W-1:0]   UNLOCK_LAST = BAD_W'(UNLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [N_PRBS-1:0]   hist;
  logic [N_PRBS-1:0]   hist_next;
  logic [EXT_W-1:0]    ext;
  logic [W-1:0]        err_bits;
  logic [NERR_W-1:0]   nerr;
  logic [CLEAN_W-1:0]  clean_run;
  logic [BAD_W-1:0]    bad_run;
  logic                active;
  logic                word_clean;
  logic                lock_now;
  logic                unlock_now;
  logic [CNT_W:0]      err_sum;
  logic [CNT_W:0]      bit_sum;

  // The serial stream is laid out oldest-first in ext: the history register
  // fills the low N_PRBS positions (hist[0] is the newest of those), followed
  // by the word with din[W-1] as the earliest bit. ext[i] is serial bit
  // s[i-N_PRBS].
  always_comb begin
    ext = '0;
    for (int m = 0; m < int'(N_PRBS); m++) begin
      ext[N_PRBS-1-m] = hist[m];
    end
    for (int k = 0; k < int'(W); k++) begin
      ext[N_PRBS+k] = din[W-1-k];
    end
  end

  // Each bit is predicted from the received bits at the tapped delays, which
  // makes a single flipped bit show up once directly and once per tap.
  always_comb begin
    logic exp_bit;
    exp_bit  = 1'b0;
    err_bits = '0;
    nerr     = '0;
    for (int k = 0; k < int'(W); k++) begin
      exp_bit = 1'b0;
      for (int j = 0; j < int'(N_PRBS); j++) begin
        if (EQN[j]) begin
          exp_bit = exp_bit ^ ext[N_PRBS+k-j-1];
        end
      end
      err_bits[k] = ext[N_PRBS+k] ^ exp_bit;
      nerr        = nerr + NERR_W'(err_bits[k]);
    end
  end

  // The newest N_PRBS serial bits become the history for the next word.
  always_comb begin
    hist_next = '0;
    for (int m = 0; m < int'(N_PRBS); m++) begin
      hist_next[m] = ext[EXT_W-1-m];
    end
  end

  // A word is only consumed when enabled and out of IDLE; the cycle that
  // leaves IDLE does not look at din.
  assign active     = en && din_valid && (state != IDLE);
  assign word_clean = (nerr == '0);
  assign lock_now   = active && (state == SEARCH) && word_clean  && (clean_run == LOCK_LAST);
  assign unlock_now = active && (state == LOCKED) && !word_clean && (bad_run == UNLOCK_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; dropping en overrides everything else.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = SEARCH;
        SEARCH:  if (lock_now)   state_next = LOCKED;
        LOCKED:  if (unlock_now) state_next = SEARCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Run counters for lock hysteresis. Both are cleared on every state change
  // so each state starts its own run from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_run <= '0;
      bad_run   <= '0;
    end else if (!en || state == IDLE || lock_now || unlock_now) begin
      clean_run <= '0;
      bad_run   <= '0;
    end else if (active) begin
      if (state == SEARCH) begin
        clean_run <= word_clean ? clean_run + 1'b1 : '0;
        bad_run   <= '0;
      end else begin
        bad_run   <= word_clean ? '0 : bad_run + 1'b1;
        clean_run <= '0;
      end
    end
  end

  // History follows every consumed word and holds across gaps and in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (active) begin
      hist <= hist_next;
    end
  end

  // Errored-word flag is reported in SEARCH as well as LOCKED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_word <= 1'b0;
    end else begin
      err_word <= active && !word_clean;
    end
  end

  // One extra bit catches the carry; a carry means the count is pinned at
  // all-ones instead of wrapping.
  assign err_sum = {1'b0, err_cnt} + (CNT_W+1)'(nerr);
  assign bit_sum = {1'b0, bit_cnt} + (CNT_W+1)'(W);

  // BER counters run only in LOCKED, including the word that drops lock.
  // A clear in the same cycle discards that word's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      bit_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
      bit_cnt <= '0;
    end else if (active && state == LOCKED) begin
      err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      bit_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_rx_checker
//
// Directed bench for prbs_rx_checker. Two instances share all stimulus: the
// default 32-bit counter build and an 8-bit counter build used to observe
// saturation. The stream source is a bench-side x^7+x^6+1 generator; faults
// are injected by flipping or inverting generated words.
// ---------------------------------------------------------------------------
module tb_prbs_rx_checker;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        din_valid;
  logic [15:0] din;
  logic        clr_cnt;

  logic        locked;
  logic        err_word;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;

  logic        locked8;
  logic        err_word8;
  logic [7:0]  err_cnt8;
  logic [7:0]  bit_cnt8;

  int          checks;
  int          errors;
  logic [6:0]  gen;
  int          err_base;

  prbs_rx_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_word  (err_word),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  prbs_rx_checker #(.CNT_W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked8),
    .err_word  (err_word8),
    .err_cnt   (err_cnt8),
    .bit_cnt   (bit_cnt8)
  );

  always #5 clk = ~clk;

  // Next 16 bits of the reference PRBS7 stream, earliest bit in w[15].
  task automatic gen_word(output logic [15:0] w);
    logic nb;
    for (int i = 0; i < 16; i++) begin
      nb       = gen[5] ^ gen[6];
      gen      = {gen[5:0], nb};
      w[15-i]  = nb;
    end
  endtask

  // Serial reference for the number of mismatching bits in a word given the
  // seven preceding received bits (h[0] newest).
  task automatic calc_nerr(input logic [15:0] w, inout logic [6:0] h, output int n);
    logic b;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      b = w[15-k];
      if (b != (h[5] ^ h[6])) n++;
      h = {h[5:0], b};
    end
  endtask

  // Present one word for one clock edge; outputs are read 1 ns after it.
  task automatic drive(input logic [15:0] w, input logic v, input logic clr);
    @(negedge clk);
    din       = w;
    din_valid = v;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (locked !== 1'b0)    begin errors++; $display("[TB] FAIL reset_locked: got %0b expected 0", locked); end
    checks++; if (err_word !== 1'b0)  begin errors++; $display("[TB] FAIL reset_err_word: got %0b expected 0", err_word); end
    checks++; if (err_cnt !== 32'd0)  begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (bit_cnt !== 32'd0)  begin errors++; $display("[TB] FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  // Clean stream from reset: one priming word against the zero history,
  // eight clean words to lock, then 100 counted words.
  task automatic test_clean_lock;
    logic [15:0] w;
    drive(16'h0000, 1'b0, 1'b0);
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (err_word !== 1'b1) begin errors++; $display("[TB] FAIL prime_err_word: got %0b expected 1", err_word); end
    for (int i = 0; i < 8; i++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
      if (i == 6) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_early: got %0b expected 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1)   begin errors++; $display("[TB] FAIL lock_8: got %0b expected 1", locked); end
    checks++; if (err_word !== 1'b0) begin errors++; $display("[TB] FAIL lock_err_word: got %0b expected 0", err_word); end
    checks++; if (bit_cnt !== 32'd0) begin errors++; $display("[TB] FAIL lock_bit_cnt: got %0d expected 0", bit_cnt); end
    for (int i = 0; i < 100; i++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
    end
    checks++; if (err_cnt !== 32'd0)    begin errors++; $display("[TB] FAIL clean_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (bit_cnt !== 32'd1600) begin errors++; $display("[TB] FAIL clean_bit_cnt: got %0d expected 1600", bit_cnt); end
    checks++; if (bit_cnt8 !== 8'd255)  begin errors++; $display("[TB] FAIL sat_bit_cnt8: got %0d expected 255", bit_cnt8); end
  endtask

  // Flip s[13] of a word: errors at k=13 in that word and k=3,4 in the next.
  task automatic test_single_flip;
    logic [15:0] w;
    gen_word(w);
    drive(w ^ 16'h0004, 1'b1, 1'b0);
    checks++; if (err_word !== 1'b1) begin errors++; $display("[TB] FAIL flip_a_err_word: got %0b expected 1", err_word); end
    checks++; if (err_cnt !== 32'd1) begin errors++; $display("[TB] FAIL flip_a_err_cnt: got %0d expected 1", err_cnt); end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (err_word !== 1'b1) begin errors++; $display("[TB] FAIL flip_b_err_word: got %0b expected 1", err_word); end
    checks++; if (err_cnt !== 32'd3) begin errors++; $display("[TB] FAIL flip_b_err_cnt: got %0d expected 3", err_cnt); end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (err_word !== 1'b0)    begin errors++; $display("[TB] FAIL flip_c_err_word: got %0b expected 0", err_word); end
    checks++; if (err_cnt !== 32'd3)    begin errors++; $display("[TB] FAIL flip_c_err_cnt: got %0d expected 3", err_cnt); end
    checks++; if (locked !== 1'b1)      begin errors++; $display("[TB] FAIL flip_locked: got %0b expected 1", locked); end
    checks++; if (bit_cnt !== 32'd1648) begin errors++; $display("[TB] FAIL flip_bit_cnt: got %0d expected 1648", bit_cnt); end
  endtask

  // Four garbage words in a row drop lock; all four are counted.
  task automatic test_unlock;
    logic [15:0] rw [4];
    logic [6:0]  h;
    int          n;
    int          sum;
    rw  = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0F0F};
    h   = gen;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      calc_nerr(rw[i], h, n);
      sum += n;
      drive(rw[i], 1'b1, 1'b0);
      checks++; if (err_word !== 1'b1) begin errors++; $display("[TB] FAIL unlock_err_word_%0d: got %0b expected 1", i, err_word); end
      checks++; if (locked !== (i < 3)) begin errors++; $display("[TB] FAIL unlock_locked_%0d: got %0b expected %0b", i, locked, (i < 3)); end
    end
    err_base = 3 + sum;
    checks++; if (err_cnt !== 32'(err_base)) begin errors++; $display("[TB] FAIL unlock_err_cnt: got %0d expected %0d", err_cnt, err_base); end
    checks++; if (err_cnt8 !== 8'(err_base)) begin errors++; $display("[TB] FAIL unlock_err_cnt8: got %0d expected %0d", err_cnt8, err_base); end
    checks++; if (bit_cnt !== 32'd1712)      begin errors++; $display("[TB] FAIL unlock_bit_cnt: got %0d expected 1712", bit_cnt); end
  endtask

  // Gapped clean stream. The generator is re-seeded with the history the
  // last garbage word left behind (0x0F0F -> 7'h0F) so no priming is needed.
  task automatic test_valid_gaps;
    logic [15:0] w;
    gen = 7'h0F;
    for (int i = 0; i < 8; i++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
      if (i == 6) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL gap_lock_early: got %0b expected 0", locked); end
      end
      if (i == 7) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL gap_lock: got %0b expected 1", locked); end
      end
      drive(16'hDEAD, 1'b0, 1'b0);
      if (i == 3) begin
        checks++; if (err_word !== 1'b0) begin errors++; $display("[TB] FAIL gap_err_word: got %0b expected 0", err_word); end
      end
    end
    checks++; if (bit_cnt !== 32'd1712) begin errors++; $display("[TB] FAIL gap_search_bit_cnt: got %0d expected 1712", bit_cnt); end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (bit_cnt !== 32'd1728) begin errors++; $display("[TB] FAIL gap_bit_cnt_1: got %0d expected 1728", bit_cnt); end
    drive(16'hBEEF, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 32'd1728) begin errors++; $display("[TB] FAIL gap_bit_cnt_hold: got %0d expected 1728", bit_cnt); end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (bit_cnt !== 32'd1744) begin errors++; $display("[TB] FAIL gap_bit_cnt_2: got %0d expected 1744", bit_cnt); end
    checks++; if (err_cnt !== 32'(err_base)) begin errors++; $display("[TB] FAIL gap_err_cnt: got %0d expected %0d", err_cnt, err_base); end
  endtask

  // An inverted word costs 15 errors and the following word 1, and never
  // more than two errored words in a row, so lock holds while 16 such
  // triples push the 8-bit counter past 255.
  task automatic test_saturation;
    logic [15:0] w;
    for (int i = 0; i < 16; i++) begin
      gen_word(w);
      drive(~w, 1'b1, 1'b0);
      gen_word(w);
      drive(w, 1'b1, 1'b0);
      gen_word(w);
      drive(w, 1'b1, 1'b0);
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL sat_locked: got %0b expected 1", locked); end
    checks++; if (err_cnt !== 32'(err_base + 256)) begin errors++; $display("[TB] FAIL sat_err_cnt: got %0d expected %0d", err_cnt, err_base + 256); end
    checks++; if (err_cnt8 !== 8'd255)  begin errors++; $display("[TB] FAIL sat_err_cnt8: got %0d expected 255", err_cnt8); end
    checks++; if (bit_cnt !== 32'd2512) begin errors++; $display("[TB] FAIL sat_bit_cnt: got %0d expected 2512", bit_cnt); end
    gen_word(w);
    drive(~w, 1'b1, 1'b1);
    checks++; if (err_cnt !== 32'd0)  begin errors++; $display("[TB] FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (err_cnt8 !== 8'd0)  begin errors++; $display("[TB] FAIL clr_err_cnt8: got %0d expected 0", err_cnt8); end
    checks++; if (bit_cnt !== 32'd0)  begin errors++; $display("[TB] FAIL clr_bit_cnt: got %0d expected 0", bit_cnt); end
    checks++; if (err_word !== 1'b1)  begin errors++; $display("[TB] FAIL clr_err_word: got %0b expected 1", err_word); end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (err_cnt !== 32'd1)  begin errors++; $display("[TB] FAIL post_clr_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (bit_cnt !== 32'd16) begin errors++; $display("[TB] FAIL post_clr_bit_cnt: got %0d expected 16", bit_cnt); end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (err_cnt !== 32'd1)  begin errors++; $display("[TB] FAIL post_clr2_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (bit_cnt !== 32'd32) begin errors++; $display("[TB] FAIL post_clr2_bit_cnt: got %0d expected 32", bit_cnt); end
  endtask

  // Reset between clock edges, relock from a zero history, then en=0.
  task automatic test_reset_relock_disable;
    logic [15:0] w;
    gen_word(w);
    drive(~w, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0)   begin errors++; $display("[TB] FAIL async_locked: got %0b expected 0", locked); end
    checks++; if (err_word !== 1'b0) begin errors++; $display("[TB] FAIL async_err_word: got %0b expected 0", err_word); end
    checks++; if (err_cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (bit_cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_bit_cnt: got %0d expected 0", bit_cnt); end
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b1;
    drive(16'h0000, 1'b0, 1'b0);
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    checks++; if (err_word !== 1'b1) begin errors++; $display("[TB] FAIL relock_prime: got %0b expected 1", err_word); end
    for (int i = 0; i < 8; i++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
      if (i == 6) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %0b expected 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL relock: got %0b expected 1", locked); end
    for (int i = 0; i < 3; i++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
    end
    checks++; if (bit_cnt !== 32'd48) begin errors++; $display("[TB] FAIL relock_bit_cnt: got %0d expected 48", bit_cnt); end
    en = 1'b0;
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL dis_locked: got %0b expected 0", locked); end
    drive(16'h5A5A, 1'b1, 1'b0);
    checks++; if (err_word !== 1'b0)  begin errors++; $display("[TB] FAIL idle_err_word: got %0b expected 0", err_word); end
    checks++; if (bit_cnt !== 32'd48) begin errors++; $display("[TB] FAIL idle_bit_cnt: got %0d expected 48", bit_cnt); end
    checks++; if (err_cnt !== 32'd0)  begin errors++; $display("[TB] FAIL idle_err_cnt: got %0d expected 0", err_cnt); end
    en = 1'b1;
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0)    begin errors++; $display("[TB] FAIL reen_locked: got %0b expected 0", locked); end
    checks++; if (bit_cnt !== 32'd48) begin errors++; $display("[TB] FAIL reen_bit_cnt: got %0d expected 48", bit_cnt); end
  endtask

  // Scenario sequence; every task leaves the DUT in a known state for the next.
  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    clr_cnt   = 1'b0;
    checks    = 0;
    errors    = 0;
    gen       = 7'h01;
    err_base  = 0;
    $display("[TB] starting prbs_rx_checker scenarios");
    test_reset;
    test_clean_lock;
    test_single_flip;
    test_unlock;
    test_valid_gaps;
    test_saturation;
    test_reset_relock_disable;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
